rtc_display_scanner: RTL and testbench
======================================

Name: rtc_display_scanner

Overview:
- Reader side of the BCD real-time-clock bus.
- Captures the hr/min/sec BCD words (two packed 4-bit digits each, tens in [7:4]) on a load strobe.
- Time-multiplexes the six digits onto one common 7-segment bus with per-digit enables, plus a seconds colon and a sticky invalid-time flag.
- Sits between the RTC counter and the board display pins.

Parameters:
- SCAN_DIV, 4, clock cycles per digit slot. Legal range is 2..65535.
- BLANK_LEAD, 1, when 1, blank the hour-tens digit if it is 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- sec  in  8  BCD seconds from the RTC.
- min  in  8  BCD minutes from the RTC.
- hr  in  8  BCD hours from the RTC.
- load  in  1  capture strobe for sec/min/hr; sampled every clk.
- seg  out  7  segments {a,b,c,d,e,f,g}, active-high; a is bit 6, g is bit 0.
- an  out  6  one-hot digit enable, active-high.
  - bit 0 = sec units, 1 = sec tens, 2 = min units, 3 = min tens, 4 = hr units, 5 = hr tens.
- colon  out  1  on for even seconds.
- bcd_err  out  1  sticky flag: an invalid time was loaded.

Behaviour:
- Reset is asynchronous, active-high, and takes effect immediately mid-operation. All of the following clear to 0:
  - snapshot registers snap_sec, snap_min, snap_hr;
  - prescaler pc and digit index di (range 0..5);
  - outputs seg, an, colon, bcd_err.
- Snapshot load:
  - On a clk edge with load=1, the snap registers take hr/min/sec.
  - The display reads only the snap registers, so no tearing mid-frame.
- Prescaler and digit index, updated every clk:
  - If pc==SCAN_DIV-1: pc<=0, and di<=0 if di==5, else di+1.
  - Otherwise: pc<=pc+1.
  - Frame length is 6*SCAN_DIV cycles. di wraps 5->0 with no gap.
- Registered outputs, computed from the current pc, di and snap values (one cycle of latency):
  - Anti-ghost gap: when pc==0, an<=0 and seg<=0.
  - Otherwise an<=onehot(di) and seg<=decode(digit[di]).
  - The first enabled digit appears on the 2nd edge after reset release: an=000001.
- Segment decode:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011.
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Any nibble >9 shows 0000001 ("-").
- Leading-zero blanking: if BLANK_LEAD=1, di==5 and snap_hr[7:4]==0, then seg<=0000000 while an[5] is still asserted in that slot.
- Colon: colon<=~snap_sec[0] every cycle, registered, independent of scan.
- bcd_err is set on a load edge if any loaded field is invalid:
  - any nibble >9;
  - sec[7:4]>5 or min[7:4]>5;
  - hr[7:4]>2;
  - hr[7:4]==2 and hr[3:0]>3.
- bcd_err stays set until rst; a later valid load does not clear it.
- load during an active slot: the new snap value is visible on seg one cycle after the load edge. Slot timing (pc, di) is unaffected.
- load held high continuously: snap tracks the inputs every cycle. This is legal.
- No combinational path from inputs to outputs.

Test Plan:
All scenarios use SCAN_DIV=4, BLANK_LEAD=1.
- Basic scan:
  - Stimulus: rst pulse, then load hr=12h, min=34h, sec=56h.
  - Response: an cycles 000000,000001×3, 000000,000010×3 … 100000×3, then repeats every 24 cycles.
  - seg patterns: digit0=1011111 (6), digit1=1011011 (5), digit2=0110011 (4), digit3=1111001 (3), digit4=1101101 (2), digit5=0110000 (1).
  - colon=1, bcd_err=0.
- Leading-zero blank:
  - Stimulus: load hr=09h, min=00h, sec=01h.
  - Response: in slot 5, an=100000 and seg=0000000.
  - Slot 4 seg=1111011; colon=0.
- Invalid digit:
  - Stimulus: load sec=6Ah.
  - Response: bcd_err=1 on the next edge; slot 0 seg=0000001; slot 1 seg=1011111.
  - A subsequent load of sec=00h leaves bcd_err=1.
- Invalid hour:
  - Stimulus: load hr=24h from a clean reset.
  - Response: bcd_err=1; slot 5 shows 2 and slot 4 shows 4 (no masking).
- Mid-slot reload:
  - Stimulus: during slot 0 at pc=2, load sec=57h.
  - Response: seg changes from the 6 pattern to 1110000 on the next edge; an stays at 000001; slot length is unchanged.
- Asynchronous reset mid-scan:
  - Stimulus: assert rst between clock edges during slot 3.
  - Response: seg, an, colon and bcd_err go to 0 immediately without waiting for a clock edge.
  - After release, the scan restarts at slot 0 and displays 00:00:00 (slot 5 blanked).

Source files
------------

// File: rtl/rtc_display_scanner.sv
// rtc_display_scanner: snapshots BCD hh:mm:ss on a load strobe and scans the six
// digits onto a shared 7-segment bus with one-hot enables, colon and sticky error flag.
module rtc_display_scanner #(
   parameter int SCAN_DIV   = 4,
   parameter bit BLANK_LEAD = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] sec,
   input  logic [7:0] min,
   input  logic [7:0] hr,
   input  logic       load,
   output logic [6:0] seg,
   output logic [5:0] an,
   output logic       colon,
   output logic       bcd_err
);
   logic [7:0]  snap_sec_q, snap_sec_d, snap_min_q, snap_min_d, snap_hr_q, snap_hr_d;
   logic [15:0] pc_q, pc_d;
   logic [2:0]  di_q, di_d;
   logic [6:0]  seg_q, seg_d;
   logic [5:0]  an_q, an_d;
   logic        colon_q, colon_d, err_q, err_d;
   logic        slot_end, bad;
   logic [3:0]  nib;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'd0:    seg7 = 7'b1111110;
         4'd1:    seg7 = 7'b0110000;
         4'd2:    seg7 = 7'b1101101;
         4'd3:    seg7 = 7'b1111001;
         4'd4:    seg7 = 7'b0110011;
         4'd5:    seg7 = 7'b1011011;
         4'd6:    seg7 = 7'b1011111;
         4'd7:    seg7 = 7'b1110000;
         4'd8:    seg7 = 7'b1111111;
         4'd9:    seg7 = 7'b1111011;
         default: seg7 = 7'b0000001;
      endcase
   endfunction

   always_comb begin
      snap_sec_d = load ? sec : snap_sec_q;
      snap_min_d = load ? min : snap_min_q;
      snap_hr_d  = load ? hr  : snap_hr_q;
      bad = sec[3:0] > 4'd9 || sec[7:4] > 4'd5 || min[3:0] > 4'd9 || min[7:4] > 4'd5 ||
            hr[3:0] > 4'd9 || hr[7:4] > 4'd2 || (hr[7:4] == 4'd2 && hr[3:0] > 4'd3);
      err_d = err_q | (load & bad);
      slot_end = pc_q == 16'(SCAN_DIV - 1);
      pc_d = slot_end ? '0 : pc_q + 16'd1;
      di_d = slot_end ? ((di_q == 3'd5) ? '0 : di_q + 3'd1) : di_q;
      nib = (di_q == 3'd0) ? snap_sec_q[3:0] :
            (di_q == 3'd1) ? snap_sec_q[7:4] :
            (di_q == 3'd2) ? snap_min_q[3:0] :
            (di_q == 3'd3) ? snap_min_q[7:4] :
            (di_q == 3'd4) ? snap_hr_q[3:0]  : snap_hr_q[7:4];
      // pc==0 is a dark cycle between digits so the previous digit does not ghost
      an_d = (pc_q == '0) ? '0 : 6'd1 << di_q;
      seg_d = (pc_q == '0 || (BLANK_LEAD && di_q == 3'd5 && snap_hr_q[7:4] == 4'd0)) ? '0 : seg7(nib);
      colon_d = ~snap_sec_q[0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_sec_q <= '0;
         snap_min_q <= '0;
         snap_hr_q  <= '0;
         pc_q       <= '0;
         di_q       <= '0;
         seg_q      <= '0;
         an_q       <= '0;
         colon_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         snap_sec_q <= snap_sec_d;
         snap_min_q <= snap_min_d;
         snap_hr_q  <= snap_hr_d;
         pc_q       <= pc_d;
         di_q       <= di_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
         colon_q    <= colon_d;
         err_q      <= err_d;
      end
   end

   assign seg     = seg_q;
   assign an      = an_q;
   assign colon   = colon_q;
   assign bcd_err = err_q;
endmodule

// File: tb/tb_rtc_display_scanner.sv
// tb_rtc_display_scanner: directed checks of scan timing, decode, blanking, error flag and async reset.
module tb_rtc_display_scanner;
   logic       clk = 1'b0, rst = 1'b1, load = 1'b0;
   logic [7:0] sec = '0, min = '0, hr = '0;
   logic [6:0] seg;
   logic [5:0] an;
   logic       colon, bcd_err;
   int         passed = 0, total = 0, ecount = 0, g = 0;
   logic [6:0] exp_seg [6];

   rtc_display_scanner #(.SCAN_DIV(4), .BLANK_LEAD(1'b1)) dut (
      .clk(clk), .rst(rst), .sec(sec), .min(min), .hr(hr), .load(load),
      .seg(seg), .an(an), .colon(colon), .bcd_err(bcd_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      ecount++;
   endtask

   // edge n shows what pc/di held before it: pc=(n-1)%4, di=((n-1)/4)%6
   task automatic scan(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         int p, d;
         tick();
         p = (ecount - 1) % 4;
         d = ((ecount - 1) / 4) % 6;
         chk({tag, " an"}, 32'(an), (p == 0) ? 32'd0 : 32'd1 << d);
         chk({tag, " seg"}, 32'(seg), (p == 0) ? 32'd0 : 32'(exp_seg[d]));
      end
   endtask

   task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      hr = h;
      min = m;
      sec = s;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   initial begin
      hr = 8'h12; min = 8'h34; sec = 8'h56; load = 1'b1;
      #12;
      chk("reset seg", 32'(seg), 0);
      chk("reset an", 32'(an), 0);
      chk("reset colon", 32'(colon), 0);
      chk("reset err", 32'(bcd_err), 0);
      @(negedge clk) rst = 1'b0;
      tick();
      load = 1'b0;
      chk("basic first gap", 32'(an), 0);
      exp_seg = '{7'b1011111, 7'b1011011, 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
      scan("basic", 26);
      chk("basic colon", 32'(colon), 1);
      chk("basic err", 32'(bcd_err), 0);

      do_load(8'h09, 8'h00, 8'h01);
      exp_seg = '{7'b0110000, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111011, 7'b0000000};
      scan("blank", 24);
      chk("blank colon", 32'(colon), 0);
      chk("blank err", 32'(bcd_err), 0);

      do_load(8'h09, 8'h00, 8'h6A);
      chk("inv err set", 32'(bcd_err), 1);
      exp_seg[0] = 7'b0000001;
      exp_seg[1] = 7'b1011111;
      scan("inv", 24);
      do_load(8'h09, 8'h00, 8'h00);
      chk("inv err sticky", 32'(bcd_err), 1);
      tick();
      chk("inv err sticky2", 32'(bcd_err), 1);
      chk("inv colon", 32'(colon), 1);

      g = 0;
      do begin
         tick();
         g++;
      end while (!(((ecount - 1) % 4) != 0 && ((ecount - 1) / 4) % 6 == 3) && g < 30);
      chk("async pre an", 32'(an), 32'b001000);
      #2 rst = 1'b1;
      #1;
      chk("async seg", 32'(seg), 0);
      chk("async an", 32'(an), 0);
      chk("async colon", 32'(colon), 0);
      chk("async err", 32'(bcd_err), 0);
      ecount = 0;
      @(negedge clk) rst = 1'b0;
      tick();
      chk("restart gap", 32'(an), 0);
      exp_seg = '{7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 7'b0000000};
      scan("restart", 24);
      chk("restart colon", 32'(colon), 1);

      rst = 1'b1;
      ecount = 0;
      hr = 8'h24; min = 8'h00; sec = 8'h00; load = 1'b1;
      @(negedge clk) rst = 1'b0;
      tick();
      load = 1'b0;
      chk("hr24 err", 32'(bcd_err), 1);
      exp_seg = '{7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 7'b0110011, 7'b1101101};
      scan("hr24", 24);

      rst = 1'b1;
      #1;
      chk("reload err clr", 32'(bcd_err), 0);
      ecount = 0;
      hr = 8'h12; min = 8'h34; sec = 8'h56; load = 1'b1;
      @(negedge clk) rst = 1'b0;
      tick();
      load = 1'b0;
      tick();
      chk("reload an e2", 32'(an), 32'b000001);
      chk("reload seg e2", 32'(seg), 32'b1011111);
      sec = 8'h57;
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("reload seg e3", 32'(seg), 32'b1011111);
      tick();
      chk("reload seg e4", 32'(seg), 32'b1110000);
      chk("reload an e4", 32'(an), 32'b000001);
      tick();
      chk("reload gap e5", 32'(an), 0);
      tick();
      chk("reload an e6", 32'(an), 32'b000010);
      chk("reload seg e6", 32'(seg), 32'b1011011);
      chk("reload colon", 32'(colon), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
